// File: rtl/port_fwd_pipe.sv
// Multi-channel elastic register pipeline with per-transfer channel tie-off,
// output change pulses and a wrapping output-transfer counter.

module port_fwd_lane #(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] TIE_W = '0
) (
  input  logic             tie,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] prev,
  output logic             chg
);
  assign dout = tie ? TIE_W : din;
  assign chg  = (cur != prev);
endmodule

module port_fwd_pipe #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned NCH     = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIE_VAL = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       tie_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_chg,
  output logic [CNT_W-1:0]     xfer_cnt
);
  localparam int unsigned      DW    = NCH * WIDTH;
  localparam logic [WIDTH-1:0] TIE_W = WIDTH'(TIE_VAL);

  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][DW-1:0] stg;
  logic [DEPTH-1:0]         vld_src;
  logic [DEPTH-1:0][DW-1:0] dat_src;
  logic [DEPTH:0]           rdy;
  logic [DW-1:0]            in_word;
  logic [DW-1:0]            hist;
  logic [NCH-1:0]           chg_nxt;
  logic                     xfer;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    port_fwd_lane #(.WIDTH(WIDTH), .TIE_W(TIE_W)) u_lane (
      .tie  (tie_mask[c]),
      .din  (in_data[c*WIDTH +: WIDTH]),
      .dout (in_word[c*WIDTH +: WIDTH]),
      .cur  (out_data[c*WIDTH +: WIDTH]),
      .prev (hist[c*WIDTH +: WIDTH]),
      .chg  (chg_nxt[c])
    );
  end

  // Stage k is ready when it or any stage downstream of it holds a bubble;
  // expressed without a chain so rdy never feeds itself.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < DEPTH; j++)
        if (!vld_pipe[j]) rdy[k] = 1'b1;
    end
  end

  always_comb begin
    vld_src    = '0;
    dat_src    = '0;
    vld_src[0] = in_valid;
    dat_src[0] = in_word;
    for (int k = 1; k < DEPTH; k++) begin
      vld_src[k] = vld_pipe[k-1];
      dat_src[k] = stg[k-1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = stg[DEPTH-1];
  assign xfer      = out_valid && out_ready;

  // Data only moves with a valid word so an emptied stage keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      stg      <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_src[k];
          if (vld_src[k]) stg[k] <= dat_src[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      out_chg  <= '0;
      xfer_cnt <= '0;
    end else begin
      out_chg <= xfer ? chg_nxt : '0;
      if (xfer) begin
        hist     <= out_data;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_port_fwd_pipe.sv
// Randomized scoreboard bench for port_fwd_pipe with directed latency,
// backpressure, tie truncation and asynchronous reset scenarios.

module tb_port_fwd_pipe;
  localparam int WIDTH   = 2;
  localparam int NCH     = 3;
  localparam int DEPTH   = 3;
  localparam int TIE_VAL = 5;
  localparam int CNT_W   = 3;
  localparam int DW      = NCH * WIDTH;
  localparam int TV      = TIE_VAL % (1 << WIDTH);

  typedef logic [DW-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]    in_data, out_data;
  logic [NCH-1:0]   tie_mask, out_chg;
  logic [CNT_W-1:0] xfer_cnt;

  port_fwd_pipe #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TIE_VAL(TIE_VAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tie_mask(tie_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chg(out_chg), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  word_t          q[$];
  word_t          m_hist = '0;
  logic [NCH-1:0] m_chg = '0;
  int             m_cnt = 0;
  logic           mon_en = 1'b0;
  logic           hold_prev = 1'b0;
  word_t          held = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic word_t model_word(word_t d, logic [NCH-1:0] m);
    word_t          r;
    logic [31:0]    tv32;
    tv32 = TV;
    for (int c = 0; c < NCH; c++)
      r[c*WIDTH +: WIDTH] = m[c] ? tv32[WIDTH-1:0] : d[c*WIDTH +: WIDTH];
    return r;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      word_t exp;
      chk("in_ready", in_ready, (q.size() < DEPTH) || out_ready);
      chk("out_chg", out_chg, m_chg);
      chk("xfer_cnt", xfer_cnt, m_cnt);
      if (q.size() == 0) chk("empty_valid", out_valid, 0);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      hold_prev = out_valid && !out_ready;
      held      = out_data;
      if (out_valid && out_ready && q.size() > 0) begin
        exp = q.pop_front();
        chk("out_data", out_data, exp);
        for (int c = 0; c < NCH; c++)
          m_chg[c] = (exp[c*WIDTH +: WIDTH] != m_hist[c*WIDTH +: WIDTH]);
        m_hist = exp;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_chg = '0;
      end
      if (in_valid && in_ready) q.push_back(model_word(in_data, tie_mask));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts.
  task automatic send(word_t d, logic [NCH-1:0] m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    tie_mask = m;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int    n;
    logic  acc;
    word_t hd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tie_mask = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chg", out_chg, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1; mon_en = 1'b1;

    // Latency from accept to first out_valid.
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(6'b01_10_11, '0);
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, DEPTH);
    drain();

    // Back-to-back stream emerges on consecutive cycles.
    send(6'h01, '0); send(6'h02, '0); send(6'h03, '0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 1; i <= 3; i++) begin
      chk("stream_valid", out_valid, 1);
      @(negedge clk);
    end
    drain();

    // Backpressure: fill, stall, then release.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(word_t'(i + 9), '0);
    in_valid = 1'b1; in_data = 6'h2a; tie_mask = '0;
    repeat (2) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
    end
    hd = out_data;
    @(negedge clk);
    chk("full_stable", out_data, hd);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    drain();
    chk("no_dup_valid", out_valid, 0);

    // Full tie-off: every channel becomes truncated TIE_VAL.
    send('0, '1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("tie_trunc", out_data, 6'b01_01_01);
    drain();

    // Randomized traffic in three flavours: random, constant zero, tied.
    for (int mode = 0; mode < 3; mode++) begin
      acc = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 9) < 7);
          in_data  = (mode == 1) ? '0 : word_t'($urandom);
          tie_mask = (mode == 0) ? NCH'($urandom) : (mode == 1) ? '0 : '1;
        end
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
      end
      drain();
    end

    // Asynchronous reset with words in flight.
    out_ready = 1'b0;
    send(6'h15, '0); send(6'h2a, '0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0; mon_en = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_chg", out_chg, 0);
    chk("arst_xfer_cnt", xfer_cnt, 0);
    q.delete(); m_hist = '0; m_chg = '0; m_cnt = 0; hold_prev = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(6'b00_00_11, '0);
    in_valid = 1'b0;
    n = 0;
    while (!out_chg[0] && n < 20) begin @(negedge clk); n++; end
    chk("post_rst_chg0", out_chg[0], 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
